// File: rtl/pong_pkg.sv
// pong_pkg: shared direction encoding, key bit indices and 50 MHz timing defaults
package pong_pkg;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_NEG = 2'd1, DIR_POS = 2'd2} dir_e;
  localparam int KEY_UL = 3;
  localparam int KEY_UR = 2;
  localparam int KEY_DL = 1;
  localparam int KEY_DR = 0;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int DB_W_DEF = 20;
  localparam int MOVE_DIV_DEF = 250000;
  localparam int MV_W_DEF = 18;
  localparam int ACCEL_AFTER_DEF = 8;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser, polarity normalisation and debounce for one key
// Ports: clock, reset (sync, active-high), key_raw_i (async raw key), key_state_o (debounced, 1 = pressed)
module key_debounce import pong_pkg::*; #(
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DB_W = DB_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw_i,
  output logic key_state_o
);
  logic sync1_q, sync2_q, state_q, state_d, lvl;
  logic [DB_W-1:0] cnt_q, cnt_d;
  always_comb begin
    lvl = sync2_q ^ KEY_ACTIVE_LOW;
    state_d = (lvl != state_q && cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) ? lvl : state_q;
    cnt_d = (lvl == state_q || state_d != state_q) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= KEY_ACTIVE_LOW;
      sync2_q <= KEY_ACTIVE_LOW;
      state_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign key_state_o = state_q;
endmodule

// File: rtl/paddle_key_conditioner.sv
// paddle_key_conditioner: debounces four paddle keys and rate-limits them into one-cycle move pulses
// Ports: clock, reset (sync, active-high), key_raw[3:0] (UL,UR,DL,DR raw keys),
//        key_state[3:0] (debounced, 1 = pressed), move[3:0] (one-cycle step pulses, same mapping)
// Optional: define PONG_KEY_ACCEL_EN to halve the pulse period after ACCEL_AFTER held pulses.
module paddle_key_conditioner import pong_pkg::*; #(
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DB_W = DB_W_DEF,
  parameter int MOVE_DIV = MOVE_DIV_DEF,
  parameter int MV_W = MV_W_DEF,
  parameter int ACCEL_AFTER = ACCEL_AFTER_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_raw,
  output logic [3:0] key_state,
  output logic [3:0] move
);
  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W(DB_W)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .key_raw_i(key_raw[k]),
      .key_state_o(key_state[k])
    );
  end
  // Pair p: bit 2p+1 is the left (NEG) key, bit 2p the right (POS) key.
  for (genvar p = 0; p < 2; p++) begin : g_pair
    dir_e dir, prev_q;
    logic [MV_W-1:0] cnt_q, cnt_d, wrap;
    logic [1:0] mv_q, mv_d;
    logic pulse;
`ifdef PONG_KEY_ACCEL_EN
    localparam int AC_W = $clog2(ACCEL_AFTER + 1);
    logic [AC_W-1:0] acc_q, acc_d;
    always_comb begin
      wrap = (acc_q == AC_W'(ACCEL_AFTER)) ? MV_W'((MOVE_DIV >> 1) - 1) : MV_W'(MOVE_DIV - 1);
      acc_d = (dir == DIR_NONE) ? '0 :
              (dir != prev_q) ? AC_W'(1) :
              (pulse && acc_q != AC_W'(ACCEL_AFTER)) ? acc_q + 1'b1 : acc_q;
    end
    always_ff @(posedge clock) acc_q <= reset ? '0 : acc_d;
`else
    assign wrap = MV_W'(MOVE_DIV - 1);
`endif
    always_comb begin
      dir = (key_state[2*p+1] && !key_state[2*p]) ? DIR_NEG :
            (key_state[2*p] && !key_state[2*p+1]) ? DIR_POS : DIR_NONE;
      pulse = (dir != DIR_NONE) && (dir != prev_q || cnt_q == wrap);
      cnt_d = (dir == DIR_NONE || pulse) ? '0 : cnt_q + 1'b1;
      mv_d = {pulse && dir == DIR_NEG, pulse && dir == DIR_POS};
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        prev_q <= DIR_NONE;
        cnt_q <= '0;
        mv_q <= '0;
      end else begin
        prev_q <= dir;
        cnt_q <= cnt_d;
        mv_q <= mv_d;
      end
    end
    assign move[2*p+1:2*p] = mv_q;
  end
endmodule

// File: tb/tb_paddle_key_conditioner.sv
// tb_paddle_key_conditioner: scoreboard bench for the key conditioner with short debounce and move periods
module tb_paddle_key_conditioner;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] key_state, move;
  int ecount = 0;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  int exp_t[$];
  logic [3:0] exp_m[$];
  int n, m, r;
  always #5 clock = ~clock;
  always @(posedge clock) ecount <= ecount + 1;
  paddle_key_conditioner #(
    .KEY_ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(4),
    .DB_W(3),
    .MOVE_DIV(8),
    .MV_W(4),
    .ACCEL_AFTER(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_raw(key_raw),
    .key_state(key_state),
    .move(move)
  );
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at edge %0d", name, act, req, ecount - 1);
    end
  endtask
  task automatic expect_pulse(input int t, input logic [3:0] mv);
    exp_t.push_back(t);
    exp_m.push_back(mv);
  endtask
  initial forever begin
    @(posedge clock);
    #1;
    if (mon_en && move !== 4'h0) begin
      total++;
      if (exp_t.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: move=%h at edge %0d, none expected", move, ecount - 1);
      end else begin
        int t;
        logic [3:0] em;
        t = exp_t.pop_front();
        em = exp_m.pop_front();
        if (t != ecount - 1 || em !== move) begin
          bad++;
          $display("FAIL pulse: got move=%h at edge %0d, want move=%h at edge %0d", move, ecount - 1, em, t);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk("reset_state", key_state, 4'h0);
    chk("reset_move", move, 4'h0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick(10);
    chk("idle_state", key_state, 4'h0);
    chk("idle_move", move, 4'h0);
    key_raw[3] = 1'b0;
    tick(3);
    key_raw[3] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("bounce_state", key_state, 4'h0);
    end
    n = ecount;
    key_raw[2] = 1'b0;
    expect_pulse(n + 6, 4'b0100);
    expect_pulse(n + 14, 4'b0100);
    expect_pulse(n + 22, 4'b0100);
    tick(5);
    chk("press_not_yet", key_state, 4'h0);
    tick(1);
    chk("press_state", key_state, 4'b0100);
    tick(18);
    key_raw[2] = 1'b1;
    tick(5);
    chk("release_not_yet", key_state, 4'b0100);
    tick(1);
    chk("release_state", key_state, 4'h0);
    tick(12);
    key_raw[1:0] = 2'b00;
    tick(6);
    chk("conflict_state", key_state, 4'b0011);
    tick(20);
    m = ecount;
    key_raw[0] = 1'b1;
    expect_pulse(m + 6, 4'b0010);
    expect_pulse(m + 14, 4'b0010);
    tick(6);
    chk("conflict_release_state", key_state, 4'b0010);
    tick(10);
    key_raw[1] = 1'b1;
    tick(15);
    chk("conflict_idle_state", key_state, 4'h0);
    n = ecount;
    key_raw[3] = 1'b0;
    expect_pulse(n + 6, 4'b1000);
    expect_pulse(n + 14, 4'b1000);
    tick(17);
    r = ecount;
    reset = 1'b1;
    tick(1);
    chk("midhold_reset_move", move, 4'h0);
    chk("midhold_reset_state", key_state, 4'h0);
    reset = 1'b0;
    expect_pulse(r + 7, 4'b1000);
    expect_pulse(r + 15, 4'b1000);
    tick(16);
    key_raw[3] = 1'b1;
    tick(12);
    chk("final_state", key_state, 4'h0);
    total++;
    if (exp_t.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses: %0d expected pulses never seen", exp_t.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
